muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers, sitting in the EX stage of the five-stage MIPS pipeline.
- Consumes StartE/MDOpE from the control unit and operands (forwarded rs/rt values) from the E-stage datapath.
- Returns Busy to the hazard unit, which stalls any md instruction in D while Start or Busy is high.
- HI/LO outputs feed the E-stage result mux for mfhi/mflo.

Parameters:
- MUL_CYCLES, 5: Busy cycles for mult/multu (legal range 1..31).
- DIV_CYCLES, 10: Busy cycles for div/divu (legal range 1..31).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle request; operation selected by MDOp.
- MDOp  in  3  operation code:
  - 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo.
  - 110/111 reserved, treated as no-op.
- D1  in  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- D2  in  32  rt operand (divisor / multiplier).
- Busy  out  1  high while an operation is in flight.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, Busy=0, HI=0, LO=0, counter=0, pending results=0.
  - Takes effect immediately, including mid-operation; the in-flight result is discarded.
- States: IDLE, MUL, DIV.
- IDLE, Start=1 sampled at edge t0:
  - MDOp 000/001: latch result into pending regs; counter=MUL_CYCLES-1; go to MUL.
  - MDOp 010/011: latch result into pending regs; counter=DIV_CYCLES-1; go to DIV.
  - MDOp 100: HI<=D1 at t0; stay IDLE; Busy stays 0.
  - MDOp 101: LO<=D1 at t0; stay IDLE; Busy stays 0.
  - Reserved codes: no state change.
- Busy is combinational from state: Busy=1 iff state is MUL or DIV.
  - Busy is not high in the Start cycle itself; it rises the cycle after. The hazard unit ORs in Start.
- MUL/DIV:
  - Each edge with counter!=0: counter decrements.
  - Edge with counter==0: HI/LO <= pending; state=IDLE.
  - Result: Busy is high for exactly N cycles (t0+1..t0+N); HI/LO hold new values from cycle t0+N+1, the same cycle Busy falls.
- Arithmetic:
  - mult: {HI,LO} = $signed(D1) * $signed(D2), 64-bit.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = signed quotient, truncated toward zero; HI = remainder, sign follows the dividend.
  - divu: unsigned quotient and remainder.
- Boundary cases:
  - Divide by zero (D2==0, div or divu): timing unchanged (Busy for DIV_CYCLES); HI/LO keep their prior values at completion.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
  - Start while Busy: ignored, including mthi/mtlo. The hazard unit guarantees this does not occur; the block still must not corrupt the in-flight op.
  - Operands are sampled only at t0; later changes to D1/D2 have no effect.
  - HI/LO read during Busy return the pre-operation values.

Test Plan:
- mult D1=0xFFFFFFFE (-2), D2=3 → Busy=1 for cycles t0+1..t0+5; from t0+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0.
- multu D1=0xFFFFFFFF, D2=0xFFFFFFFF → after 5 Busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- div D1=-7 (0xFFFFFFF9), D2=2 → Busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu D1=7, D2=2 → Busy 10 cycles; then LO=3, HI=1.
- mthi D1=0x12345678 → HI=0x12345678 next cycle, Busy never asserted. Then div by D2=0 → Busy 10 cycles, HI still 0x12345678 afterwards.
- Start mult, drive reset=0 during the 3rd Busy cycle → Busy, HI, LO drop to 0 immediately, without waiting for a clock edge. After release, Start=1 with MDOp=mtlo, D1=5 → LO=5.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Results are computed at issue and committed to HI/LO after a fixed latency.
module muldiv_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  localparam logic [4:0] MulLoad = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DivLoad = 5'(DIV_CYCLES - 1);

  logic [1:0]  stateQ, stateD;
  logic [4:0]  cntQ, cntD;
  logic [31:0] hiQ, hiD, loQ, loD;
  logic [31:0] pendHiQ, pendHiD, pendLoQ, pendLoD;

  logic signed [63:0] prodS;
  logic [63:0]        prodU;
  logic [31:0]        absA, absB, safeB, quotU, remU, quotS, remS;
  logic               divZero;

  assign prodS = $signed(D1) * $signed(D2);
  assign prodU = {32'd0, D1} * {32'd0, D2};

  // Signed division via magnitudes keeps 0x80000000 / -1 well defined.
  assign divZero = (D2 == 32'd0);
  assign absA    = D1[31] ? (~D1 + 32'd1) : D1;
  assign absB    = D2[31] ? (~D2 + 32'd1) : D2;
  assign safeB   = divZero ? 32'd1 : absB;
  assign quotU   = absA / safeB;
  assign remU    = absA % safeB;
  assign quotS   = (D1[31] ^ D2[31]) ? (~quotU + 32'd1) : quotU;
  assign remS    = D1[31] ? (~remU + 32'd1) : remU;

  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    hiD     = hiQ;
    loD     = loQ;
    pendHiD = pendHiQ;
    pendLoD = pendLoQ;
    case (stateQ)
      IDLE: begin
        if (Start) begin
          case (MDOp)
            3'b000: begin
              {pendHiD, pendLoD} = prodS;
              cntD   = MulLoad;
              stateD = MUL;
            end
            3'b001: begin
              {pendHiD, pendLoD} = prodU;
              cntD   = MulLoad;
              stateD = MUL;
            end
            3'b010, 3'b011: begin
              // A zero divisor commits the current HI/LO back unchanged.
              if (divZero) begin
                pendHiD = hiQ;
                pendLoD = loQ;
              end else if (MDOp[0]) begin
                pendHiD = D1 % D2;
                pendLoD = D1 / D2;
              end else begin
                pendHiD = remS;
                pendLoD = quotS;
              end
              cntD   = DivLoad;
              stateD = DIV;
            end
            3'b100:  hiD = D1;
            3'b101:  loD = D1;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        if (cntQ != 5'd0) begin
          cntD = cntQ - 5'd1;
        end else begin
          hiD    = pendHiQ;
          loD    = pendLoQ;
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ  <= IDLE;
      cntQ    <= 5'd0;
      hiQ     <= 32'd0;
      loQ     <= 32'd0;
      pendHiQ <= 32'd0;
      pendLoQ <= 32'd0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      hiQ     <= hiD;
      loQ     <= loD;
      pendHiQ <= pendHiD;
      pendLoQ <= pendLoD;
    end
  end

  assign Busy = (stateQ == MUL) || (stateQ == DIV);
  assign HI   = hiQ;
  assign LO   = loQ;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] D1, D2;
  logic        Busy;
  logic [31:0] HI, LO;

  int nChecks = 0;
  int nFails  = 0;
  int nBusy;

  muldiv_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .Start(Start),
    .MDOp (MDOp),
    .D1   (D1),
    .D2   (D2),
    .Busy (Busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op; the posedge inside is t0. Operands are scrambled afterwards.
  task automatic doStart(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1;
    MDOp  = op;
    D1    = a;
    D2    = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
    D1    = 32'hA5A5_5A5A;
    D2    = 32'h0000_0003;
  endtask

  // Counts Busy cycles from t0+1, bounded so a stuck Busy cannot hang the run.
  task automatic waitDone(output int n);
    n = 0;
    @(negedge clk);
    while (Busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0;
    Start = 1'b0;
    MDOp  = 3'b000;
    D1    = 32'd0;
    D2    = 32'd0;
    #12;
    checkVal("rst_busy", {31'd0, Busy}, 32'd0);
    checkVal("rst_hi", HI, 32'd0);
    checkVal("rst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    doStart(3'b000, 32'hFFFF_FFFE, 32'd3);
    checkVal("mult_busy_t0", {31'd0, Busy}, 32'd1);
    waitDone(nBusy);
    checkVal("mult_cycles", nBusy, 32'd5);
    checkVal("mult_hi", HI, 32'hFFFF_FFFF);
    checkVal("mult_lo", LO, 32'hFFFF_FFFA);

    doStart(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(nBusy);
    checkVal("multu_cycles", nBusy, 32'd5);
    checkVal("multu_hi", HI, 32'hFFFF_FFFE);
    checkVal("multu_lo", LO, 32'h0000_0001);

    doStart(3'b010, 32'hFFFF_FFF9, 32'd2);
    waitDone(nBusy);
    checkVal("div_cycles", nBusy, 32'd10);
    checkVal("div_lo", LO, 32'hFFFF_FFFD);
    checkVal("div_hi", HI, 32'hFFFF_FFFF);

    doStart(3'b011, 32'd7, 32'd2);
    waitDone(nBusy);
    checkVal("divu_cycles", nBusy, 32'd10);
    checkVal("divu_lo", LO, 32'd3);
    checkVal("divu_hi", HI, 32'd1);

    doStart(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(nBusy);
    checkVal("divovf_lo", LO, 32'h8000_0000);
    checkVal("divovf_hi", HI, 32'd0);

    doStart(3'b100, 32'h1234_5678, 32'd0);
    checkVal("mthi_hi", HI, 32'h1234_5678);
    checkVal("mthi_busy", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    checkVal("mthi_busy_next", {31'd0, Busy}, 32'd0);

    doStart(3'b010, 32'd99, 32'd0);
    waitDone(nBusy);
    checkVal("div0_cycles", nBusy, 32'd10);
    checkVal("div0_hi", HI, 32'h1234_5678);
    checkVal("div0_lo", LO, 32'h8000_0000);

    // mthi issued mid-operation must be dropped.
    doStart(3'b000, 32'd2, 32'd3);
    @(negedge clk);
    checkVal("ign_busy", {31'd0, Busy}, 32'd1);
    checkVal("ign_hi_during", HI, 32'h1234_5678);
    Start = 1'b1;
    MDOp  = 3'b100;
    D1    = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    Start = 1'b0;
    waitDone(nBusy);
    checkVal("ign_cycles", nBusy, 32'd4);
    checkVal("ign_hi", HI, 32'd0);
    checkVal("ign_lo", LO, 32'd6);

    // Asynchronous reset during the third Busy cycle.
    doStart(3'b000, 32'd5, 32'd5);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkVal("arst_pre_busy", {31'd0, Busy}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    checkVal("arst_busy", {31'd0, Busy}, 32'd0);
    checkVal("arst_hi", HI, 32'd0);
    checkVal("arst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    doStart(3'b101, 32'd5, 32'd0);
    checkVal("mtlo_lo", LO, 32'd5);
    checkVal("mtlo_busy", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    checkVal("mtlo_hi", HI, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
